// File: rtl/seven_segment_led_if.sv
// Display bus for seven_segment_led: value and blanking mask in, active-low
// anode enables and segment lines out.
interface seven_segment_led_if;
  logic [31:0] NUMBER;
  logic [7:0]  AN_MASK;
  logic [7:0]  AN;
  logic [6:0]  SEG;

  modport master (
    output NUMBER,
    output AN_MASK,
    input  AN,
    input  SEG
  );

  modport slave (
    input  NUMBER,
    input  AN_MASK,
    output AN,
    output SEG
  );
endinterface

// File: rtl/seven_segment_led.sv
// Time-multiplexed 8-digit hex driver for a common-anode seven-segment display.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the highest non-zero nibble.
module seven_segment_led #(
  parameter int unsigned SCAN_DIV = 1
) (
  input  logic            clk,
  input  logic            RESET,
  seven_segment_led_if.slave bus
);

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

  logic [15:0] cnt_reg;
  logic [2:0]  idx_reg;
  logic [7:0]  an_reg;
  logic [6:0]  seg_reg;

  logic [7:0]  lz_mask;
  logic [7:0]  blank_mask;
  logic [3:0]  nibble;
  logic [7:0]  an_next;
  logic [6:0]  seg_next;

  function automatic logic [6:0] decode(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // Digit k is a leading zero when every nibble from k upward is zero;
  // digit 0 is never blanked so a zero value still shows one "0".
  assign lz_mask[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 8; gi++) begin : g_lz
      assign lz_mask[gi] = ~|bus.NUMBER[31:4*gi];
    end
  endgenerate
`else
  assign lz_mask = 8'h00;
`endif

  assign blank_mask = bus.AN_MASK | lz_mask;
  assign nibble     = bus.NUMBER[{idx_reg, 2'b00} +: 4];

  always_comb begin
    an_next  = ~(8'd1 << idx_reg) | blank_mask;
    seg_next = blank_mask[idx_reg] ? 7'h7F : decode(nibble);
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      cnt_reg <= 16'd0;
      idx_reg <= 3'd0;
      an_reg  <= 8'hFF;
      seg_reg <= 7'h7F;
    end else begin
      an_reg  <= an_next;
      seg_reg <= seg_next;
      if (cnt_reg == DIV_LAST) begin
        cnt_reg <= 16'd0;
        idx_reg <= idx_reg + 3'd1;
      end else begin
        cnt_reg <= cnt_reg + 16'd1;
      end
    end
  end

  assign bus.AN  = an_reg;
  assign bus.SEG = seg_reg;

endmodule

// File: tb/tb_seven_segment_led.sv
// Directed bench for seven_segment_led: scan order, decode table, masking,
// prescaler (second instance with SCAN_DIV=4), reset and leading-zero blanking.
module tb_seven_segment_led;

  logic clk;
  logic RESET;
  int   checks;
  int   errors;

  seven_segment_led_if bus1 ();
  seven_segment_led_if bus4 ();

  seven_segment_led #(.SCAN_DIV(1)) dut (
    .clk   (clk),
    .RESET (RESET),
    .bus   (bus1.slave)
  );

  seven_segment_led #(.SCAN_DIV(4)) dut4 (
    .clk   (clk),
    .RESET (RESET),
    .bus   (bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed expectations
  logic [7:0] scan_an [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulse reset so the next edge after release shows digit 0
  task automatic do_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  initial begin
    logic [7:0] mask;
    checks = 0;
    errors = 0;
    RESET  = 1'b1;
    bus1.NUMBER  = 32'h7654_3210;
    bus1.AN_MASK = 8'h00;
    bus4.NUMBER  = 32'h7654_3210;
    bus4.AN_MASK = 8'h00;
    tick();
    tick();
    check("reset_an", bus1.AN, 8'hFF);
    check("reset_seg", {1'b0, bus1.SEG}, 8'h7F);
    check("reset_an4", bus4.AN, 8'hFF);

    // Scan order with wrap
    RESET = 1'b0;
    for (int e = 0; e < 9; e++) begin
      tick();
      check($sformatf("scan_an[%0d]", e), bus1.AN, scan_an[e % 8]);
      check($sformatf("scan_seg[%0d]", e), {1'b0, bus1.SEG}, {1'b0, seg_tab[e % 8]});
    end

    // Mid-scan asynchronous reset at idx=5
    for (int e = 0; e < 4; e++) tick();
    check("pre_reset_an", bus1.AN, scan_an[4]);
    #3;
    RESET = 1'b1;
    #1;
    check("async_reset_an", bus1.AN, 8'hFF);
    check("async_reset_seg", {1'b0, bus1.SEG}, 8'h7F);
    tick();
    check("held_reset_an", bus1.AN, 8'hFF);
    RESET = 1'b0;
    tick();
    check("post_reset_an", bus1.AN, 8'hFE);
    check("post_reset_seg", {1'b0, bus1.SEG}, 8'h40);

    // Upper half of decode table
    do_reset();
    bus1.NUMBER = 32'hFEDC_BA98;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("dec_seg[%0d]", 8 + k), {1'b0, bus1.SEG}, {1'b0, seg_tab[8 + k]});
    end

    // Masking digits 0 and 2, then everything
    do_reset();
    bus1.NUMBER  = 32'h7654_3210;
    bus1.AN_MASK = 8'h05;
    mask = 8'h05;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("mask_an[%0d]", k), bus1.AN, mask[k] ? 8'hFF : scan_an[k]);
      check($sformatf("mask_seg[%0d]", k), {1'b0, bus1.SEG},
            mask[k] ? 8'h7F : {1'b0, seg_tab[k]});
    end
    bus1.AN_MASK = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("mask_all_an[%0d]", k), bus1.AN, 8'hFF);
      check($sformatf("mask_all_seg[%0d]", k), {1'b0, bus1.SEG}, 8'h7F);
    end
    bus1.AN_MASK = 8'h00;

    // Prescaler: each pattern held 4 clocks, frame of 32, then wrap
    do_reset();
    for (int e = 0; e < 33; e++) begin
      tick();
      check($sformatf("div4_an[%0d]", e), bus4.AN, scan_an[(e / 4) % 8]);
      check($sformatf("div4_seg[%0d]", e), {1'b0, bus4.SEG}, {1'b0, seg_tab[(e / 4) % 8]});
    end

    // Leading zeros: 0x000000A5
    do_reset();
    bus1.NUMBER = 32'h0000_00A5;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 0) begin
        check("lz_a5_an[0]", bus1.AN, 8'hFE);
        check("lz_a5_seg[0]", {1'b0, bus1.SEG}, 8'h12);
      end else if (k == 1) begin
        check("lz_a5_an[1]", bus1.AN, 8'hFD);
        check("lz_a5_seg[1]", {1'b0, bus1.SEG}, 8'h08);
      end else begin
`ifdef LEADING_ZERO_BLANK_EN
        check($sformatf("lz_a5_an[%0d]", k), bus1.AN, 8'hFF);
        check($sformatf("lz_a5_seg[%0d]", k), {1'b0, bus1.SEG}, 8'h7F);
`else
        check($sformatf("lz_a5_an[%0d]", k), bus1.AN, scan_an[k]);
        check($sformatf("lz_a5_seg[%0d]", k), {1'b0, bus1.SEG}, 8'h40);
`endif
      end
    end

    // Leading zeros: value 0
    do_reset();
    bus1.NUMBER = 32'h0000_0000;
    for (int k = 0; k < 8; k++) begin
      tick();
`ifdef LEADING_ZERO_BLANK_EN
      check($sformatf("lz_0_an[%0d]", k), bus1.AN, (k == 0) ? 8'hFE : 8'hFF);
      check($sformatf("lz_0_seg[%0d]", k), {1'b0, bus1.SEG}, (k == 0) ? 8'h40 : 8'h7F);
`else
      check($sformatf("lz_0_an[%0d]", k), bus1.AN, scan_an[k]);
      check($sformatf("lz_0_seg[%0d]", k), {1'b0, bus1.SEG}, 8'h40);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
